lcd_value_disp: RTL and testbench

//  Displays an 8-bit unsigned value as a 3-digit decimal on the Spartan-3E

---
 rtl/lcd_value_disp.sv | 183 ++++++++++++++++++
 tb/tb_lcd_value_disp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_value_disp.sv
// lcd_value_disp: shows an 8-bit unsigned value as 3 right-justified decimal
// digits on an HD44780 character LCD (4-bit bus, write-only).
// Runs the power-on init sequence, then rewrites the digits whenever value changes.
// Ports:
//   clk     in   system clock
//   rs      in   synchronous active-low reset
//   value   in   [7:0] value to display
//   lcd_e   out  LCD enable strobe
//   lcd_rs  out  LCD register select (0 command, 1 data)
//   lcd_rw  out  LCD read/write, tied 0
//   lcd_d   out  [3:0] LCD data nibble
//   sf_ce0  out  StrataFlash disable, tied 1
//   ready   out  init complete and idle
// Build option: define LCD_LABEL_EN to prefix the digits with "VAL:".
module lcd_value_disp #(
   parameter int unsigned T_PWRON = 750000,
   parameter int unsigned T_4MS   = 205000,
   parameter int unsigned T_100US = 5000,
   parameter int unsigned T_40US  = 2000,
   parameter int unsigned T_CLR   = 82000,
   parameter int unsigned T_EHI   = 12,
   parameter int unsigned T_NIB   = 50
) (
   input  logic       clk,
   input  logic       rs,
   input  logic [7:0] value,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [3:0] lcd_d,
   output logic       sf_ce0,
   output logic       ready
);
`ifdef LCD_LABEL_EN
   localparam int unsigned N_DAT = 7;
`else
   localparam int unsigned N_DAT = 3;
`endif
   typedef enum logic [2:0] {PWR_WAIT, INIT, CFG, SET_ADDR, WR_DIG, IDLE} state_t;
   // per-nibble strobe phases: data setup, enable high, data hold, post-nibble wait
   typedef enum logic [1:0] {P_SETUP, P_EHI, P_HOLD, P_GAP} phase_t;
   state_t      state_q, state_d;
   phase_t      ph_q, ph_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic        lo_q, lo_d;
   logic [7:0]  shown_q, shown_d;
   logic [3:0]  d_q, d_d;
   logic        rsel_q, rsel_d;
   logic [3:0]  h, t, u;
   logic [7:0]  h_c, t_c;
   logic [3:0][7:0] cfg;
   logic [7:0][7:0] dat;
   logic [7:0]  cur_byte;
   logic [3:0]  nib;
   logic [31:0] cur_wait, gap;
   logic        nib_only, last, busy, split;

   assign h   = 4'(shown_q / 8'd100);
   assign t   = 4'((shown_q % 8'd100) / 8'd10);
   assign u   = 4'(shown_q % 8'd10);
   assign h_c = (h == 4'd0) ? 8'h20 : {4'h3, h};
   assign t_c = (h == 4'd0 && t == 4'd0) ? 8'h20 : {4'h3, t};
   assign cfg = {8'h01, 8'h0C, 8'h06, 8'h28};

   always_comb begin
      dat = '0;
`ifdef LCD_LABEL_EN
      dat[0] = 8'h56;
      dat[1] = 8'h41;
      dat[2] = 8'h4C;
      dat[3] = 8'h3A;
      dat[4] = h_c;
      dat[5] = t_c;
      dat[6] = {4'h3, u};
`else
      dat[0] = h_c;
      dat[1] = t_c;
      dat[2] = {4'h3, u};
`endif
   end

   // description of the item (nibble or byte) the current state is sending
   always_comb begin
      busy     = state_q != PWR_WAIT && state_q != IDLE;
      nib_only = state_q == INIT;
      last     = state_q == SET_ADDR || (state_q == WR_DIG ? idx_q == 3'(N_DAT - 1) : idx_q == 3'd3);
      cur_byte = state_q == INIT ? (idx_q == 3'd3 ? 8'h20 : 8'h30) :
                 state_q == CFG ? cfg[idx_q[1:0]] : state_q == WR_DIG ? dat[idx_q] : 8'h80;
      cur_wait = state_q == INIT ? (idx_q == 3'd0 ? T_4MS : idx_q == 3'd1 ? T_100US : T_40US) :
                 (state_q == CFG && idx_q == 3'd3) ? T_CLR : T_40US;
      nib      = lo_q ? cur_byte[3:0] : cur_byte[7:4];
      split    = !nib_only && !lo_q;
      gap      = split ? T_NIB : cur_wait;
   end

   always_ff @(posedge clk) begin
      if (!rs) begin
         state_q <= PWR_WAIT;
         ph_q    <= P_SETUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         lo_q    <= 1'b0;
         shown_q <= '0;
         d_q     <= '0;
         rsel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         shown_q <= shown_d;
         d_q     <= d_d;
         rsel_q  <= rsel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q + 32'd1;
      idx_d   = idx_q;
      lo_d    = lo_q;
      shown_d = shown_q;
      // data/rs are loaded during setup and then held until the next nibble's setup
      d_d     = (busy && ph_q == P_SETUP) ? nib : d_q;
      rsel_d  = (busy && ph_q == P_SETUP) ? state_q == WR_DIG : rsel_q;
      if (state_q == PWR_WAIT) begin
         if (cnt_q == T_PWRON - 1) begin
            state_d = INIT;
            ph_d    = P_SETUP;
            cnt_d   = '0;
            idx_d   = '0;
            lo_d    = 1'b0;
         end
      end else if (state_q == IDLE) begin
         cnt_d = '0;
         if (value != shown_q) begin
            state_d = SET_ADDR;
            shown_d = value;
            ph_d    = P_SETUP;
            idx_d   = '0;
            lo_d    = 1'b0;
         end
      end else if (ph_q == P_SETUP) begin
         if (cnt_q == 32'd2) begin
            ph_d  = P_EHI;
            cnt_d = '0;
         end
      end else if (ph_q == P_EHI) begin
         if (cnt_q == T_EHI - 1) begin
            ph_d  = P_HOLD;
            cnt_d = '0;
         end
      end else if (ph_q == P_HOLD) begin
         ph_d  = P_GAP;
         cnt_d = '0;
      end else if (cnt_q == gap - 1) begin
         ph_d  = P_SETUP;
         cnt_d = '0;
         lo_d  = split;
         if (!split) begin
            idx_d = last ? 3'd0 : idx_q + 3'd1;
            if (last) begin
               state_d = state_q == INIT ? CFG : state_q == CFG ? SET_ADDR :
                         state_q == SET_ADDR ? WR_DIG : IDLE;
               // the display value is frozen on entry to SET_ADDR so a refresh never tears
               shown_d = state_q == CFG ? value : shown_q;
            end
         end
      end
   end

   always_comb begin
      lcd_e  = ph_q == P_EHI && busy;
      lcd_d  = d_q;
      lcd_rs = rsel_q;
      lcd_rw = 1'b0;
      sf_ce0 = 1'b1;
      ready  = state_q == IDLE;
   end
endmodule

// File: tb/tb_lcd_value_disp.sv
// tb_lcd_value_disp: scoreboard bench; expected LCD nibbles are queued from a text-level model and checked on each lcd_e fall.
module tb_lcd_value_disp;
   localparam int unsigned EHI = 4;
`ifdef LCD_LABEL_EN
   localparam int LBL = 8;
`else
   localparam int LBL = 0;
`endif
   logic       clk = 1'b0;
   logic       rs = 1'b0;
   logic [7:0] value = 8'd21;
   logic       lcd_e, lcd_rs, lcd_rw, sf_ce0, ready;
   logic [3:0] lcd_d;
   logic [4:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         n_fall = 0;
   int         shown_m = 0;

   lcd_value_disp #(.T_PWRON(100), .T_4MS(20), .T_100US(20), .T_40US(20), .T_CLR(20),
                    .T_EHI(EHI), .T_NIB(5)) dut (
      .clk(clk), .rs(rs), .value(value), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_d(lcd_d), .sf_ce0(sf_ce0), .ready(ready));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_byte(input logic r, input logic [7:0] b);
      exp_q.push_back({r, b[7:4]});
      exp_q.push_back({r, b[3:0]});
   endtask

   task automatic push_init();
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h02);
      push_byte(1'b0, 8'h28);
      push_byte(1'b0, 8'h06);
      push_byte(1'b0, 8'h0C);
      push_byte(1'b0, 8'h01);
   endtask

   task automatic push_refresh(input int v);
      string s;
      string lbl;
      lbl = "VAL:";
      s = $sformatf("%3d", v);
      push_byte(1'b0, 8'h80);
      if (LBL != 0)
         for (int i = 0; i < 4; i++) push_byte(1'b1, lbl[i]);
      for (int i = 0; i < 3; i++) push_byte(1'b1, s[i]);
      shown_m = v;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(exp_q.size() == 0 && ready) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", int'(n >= 20000), 0);
   endtask

   task automatic wait_falls(input int target);
      int n = 0;
      while (n_fall < target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("fall_timeout", int'(n >= 20000), 0);
   endtask

   task automatic set_value(input int v);
      if (v != shown_m) push_refresh(v);
      value = 8'(v);
      wait_done();
   endtask

   // monitor: samples away from the active edge and checks every strobed nibble
   initial begin
      logic       e_prev = 1'b0;
      logic [4:0] p_prev = '0;
      logic [4:0] ex;
      int         stab = 0;
      int         hi_w = 0;
      forever begin
         @(negedge clk);
         stab = ({lcd_rs, lcd_d} != p_prev) ? 0 : stab + 1;
         if (!e_prev && lcd_e) check("setup", int'(stab >= 2), 1);
         if (e_prev && !lcd_e) begin
            if (rs) begin
               check("e_width", hi_w, EHI);
               check("hold", {lcd_rs, lcd_d}, p_prev);
            end
            check("ready_busy", ready, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_nibble", p_prev, 5'h1f);
            end else begin
               ex = exp_q.pop_front();
               check($sformatf("nibble%0d", n_fall), p_prev, ex);
            end
            n_fall++;
         end
         hi_w = lcd_e ? hi_w + 1 : 0;
         e_prev = lcd_e;
         p_prev = {lcd_rs, lcd_d};
      end
   end

   initial begin
      int base;
      repeat (4) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_e", lcd_e, 0);
      check("rst_d", lcd_d, 0);
      check("rst_rs", lcd_rs, 0);
      check("rw", lcd_rw, 0);
      check("ce0", sf_ce0, 1);
      push_init();
      push_refresh(21);
      rs = 1'b1;
      wait_done();
      check("ready_after_init", ready, 1);
      set_value(255);
      set_value(0);
      set_value(8);
      set_value(100);
      set_value(100);
      set_value(99);
      set_value(10);
      for (int i = 0; i < 10; i++) set_value(int'($urandom_range(0, 255)));
      set_value(50);
      // value changes mid-refresh: the started refresh completes, then a new pass follows
      base = n_fall;
      push_refresh(21);
      value = 8'd21;
      wait_falls(base + 2 + LBL + 3);
      push_refresh(9);
      value = 8'd9;
      wait_done();
      check("ready_after_tear", ready, 1);
      // reset during a digit write aborts it and reruns init
      base = n_fall;
      push_refresh(123);
      value = 8'd123;
      wait_falls(base + 2 + LBL + 2);
      begin
         int n = 0;
         while (!lcd_e && n < 2000) begin
            @(negedge clk);
            n++;
         end
         check("e_rise_timeout", int'(n >= 2000), 0);
      end
      rs = 1'b0;
      @(posedge clk);
      #1;
      check("abort_e", lcd_e, 0);
      check("abort_ready", ready, 0);
      repeat (3) @(negedge clk);
      exp_q.delete();
      push_init();
      push_refresh(123);
      rs = 1'b1;
      wait_done();
      check("ready_after_reinit", ready, 1);
      set_value(7);
      repeat (300) @(negedge clk);
      check("leftover", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
